// File: rtl/cells_pkg.sv
// Shared types for the falling-sand frame updater: cell codes, FSM states, cell helpers.
package cells_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_SAND  = 2'd1,
    CELL_WALL  = 2'd2,
    CELL_RSVD  = 2'd3
  } cell_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK_SELF,
    ST_CHECK_DOWN,
    ST_CHECK_D1,
    ST_CHECK_D2,
    ST_CLEAR,
    ST_SPAWN_RD,
    ST_SPAWN_WR,
    ST_DONE
  } state_t;

  // Anything but EMPTY blocks a falling grain; the reserved code behaves like WALL.
  function automatic logic is_solid(input logic [1:0] code);
    return code != CELL_EMPTY;
  endfunction

endpackage

// File: rtl/cells_next_state_multi_if.sv
// Cell RAM port bundle: one synchronous read port (1-cycle latency) and one write port.
interface cells_next_state_multi_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int CELL_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0] rd_addr_o;
  logic [CELL_WIDTH-1:0] rd_data_i;
  logic [ADDR_WIDTH-1:0] wr_addr_o;
  logic [CELL_WIDTH-1:0] wr_data_o;
  logic                  wr_en_o;

  modport master (output rd_addr_o, wr_addr_o, wr_data_o, wr_en_o, input rd_data_i);
  modport slave  (input rd_addr_o, wr_addr_o, wr_data_o, wr_en_o, output rd_data_i);
endinterface

// File: rtl/cells_scan_counter.sv
// Bottom-up scan position: address down-counter with a column down-counter alongside,
// so edge detection needs no divider and the scan path no multiplier.
module cells_scan_counter #(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int ADDR_WIDTH     = 19,
  parameter int COL_WIDTH      = 10
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic                  dec_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o,
  output logic                  col_first_o,
  output logic                  col_last_o
);
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'((ACTIVE_ROWS - 1) * ACTIVE_COLUMNS - 1);
  localparam logic [COL_WIDTH-1:0]  COL_MAX    = COL_WIDTH'(ACTIVE_COLUMNS - 1);

  logic [COL_WIDTH-1:0] col_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_o <= '0;
      col_q  <= '0;
    end else if (load_i) begin
      addr_o <= FIRST_ADDR;
      col_q  <= COL_MAX;
    end else if (dec_i) begin
      addr_o <= addr_o - 1'b1;
      col_q  <= (col_q == '0) ? COL_MAX : col_q - 1'b1;
    end
  end

  assign last_o      = (addr_o == '0);
  assign col_first_o = (col_q == '0);
  assign col_last_o  = (col_q == COL_MAX);

endmodule

// File: rtl/cells_next_state_multi.sv
// Per-frame falling-sand updater (empty/sand/wall), bottom-up scan, alternating diagonal
// preference, row-0 spawn. Optional moved-grain statistic under `CELLS_STATS_EN.
module cells_next_state_multi
  import cells_pkg::*;
#(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
  parameter int CELL_WIDTH     = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  spawn_en_i,
  input  logic [ADDR_WIDTH-1:0] spawn_col_i,
  cells_next_state_multi_if.master ram,
`ifdef CELLS_STATS_EN
  output logic [ADDR_WIDTH-1:0] moved_count_o,
`endif
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int                    COL_WIDTH  = $clog2(ACTIVE_COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] COLS_A     = ADDR_WIDTH'(ACTIVE_COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] COL_MAX_A  = ADDR_WIDTH'(ACTIVE_COLUMNS - 1);
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'((ACTIVE_ROWS - 1) * ACTIVE_COLUMNS - 1);
  localparam logic [CELL_WIDTH-1:0] SAND_W     = CELL_WIDTH'(CELL_SAND);

  state_t                state_q, state_d;
  logic                  pref_q;
  logic                  load, dec, moved;
  logic [ADDR_WIDTH-1:0] addr, below, d1_addr, d2_addr, spawn_addr;
  logic                  last, col_first, col_last, d1_ok, d2_ok;
  logic [1:0]            rd_code;
  logic                  rd_empty, rd_sand;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
  logic [CELL_WIDTH-1:0] wr_data;
  logic                  wr_en;

  assign load = (state_q == ST_IDLE) && start_i;

  cells_scan_counter #(
    .ACTIVE_COLUMNS(ACTIVE_COLUMNS),
    .ACTIVE_ROWS   (ACTIVE_ROWS),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .COL_WIDTH     (COL_WIDTH)
  ) u_scan (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (load),
    .dec_i      (dec),
    .addr_o     (addr),
    .last_o     (last),
    .col_first_o(col_first),
    .col_last_o (col_last)
  );

  // pref_q=0 tries the left diagonal first; the out-of-grid side is treated as blocked.
  assign below      = addr + COLS_A;
  assign d1_addr    = pref_q ? below + 1'b1 : below - 1'b1;
  assign d2_addr    = pref_q ? below - 1'b1 : below + 1'b1;
  assign d1_ok      = pref_q ? !col_last  : !col_first;
  assign d2_ok      = pref_q ? !col_first : !col_last;
  assign spawn_addr = (spawn_col_i > COL_MAX_A) ? COL_MAX_A : spawn_col_i;

  assign rd_code  = ram.rd_data_i[1:0];
  assign rd_empty = !is_solid(rd_code);
  assign rd_sand  = (rd_code == CELL_SAND);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      pref_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DONE) pref_q <= !pref_q;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    wr_en   = 1'b0;
    dec     = 1'b0;
    moved   = 1'b0;
    case (state_q)
      ST_IDLE: if (start_i) begin
        rd_addr = FIRST_ADDR;
        state_d = ST_CHECK_SELF;
      end
      ST_CHECK_SELF: if (rd_sand) begin
        rd_addr = below;
        state_d = ST_CHECK_DOWN;
      end else if (last) begin
        state_d = ST_SPAWN_RD;
      end else begin
        dec     = 1'b1;
        rd_addr = addr - 1'b1;
        state_d = ST_CHECK_SELF;
      end
      ST_CHECK_DOWN: if (rd_empty) begin
        {wr_en, wr_addr, wr_data, moved} = {1'b1, below, SAND_W, 1'b1};
        state_d = ST_CLEAR;
      end else begin
        rd_addr = d1_addr;
        state_d = ST_CHECK_D1;
      end
      ST_CHECK_D1: if (d1_ok && rd_empty) begin
        {wr_en, wr_addr, wr_data, moved} = {1'b1, d1_addr, SAND_W, 1'b1};
        state_d = ST_CLEAR;
      end else begin
        rd_addr = d2_addr;
        state_d = ST_CHECK_D2;
      end
      ST_CHECK_D2: if (d2_ok && rd_empty) begin
        {wr_en, wr_addr, wr_data, moved} = {1'b1, d2_addr, SAND_W, 1'b1};
        state_d = ST_CLEAR;
      end else if (last) begin
        state_d = ST_SPAWN_RD;
      end else begin
        dec     = 1'b1;
        rd_addr = addr - 1'b1;
        state_d = ST_CHECK_SELF;
      end
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = addr;
        if (last) begin
          state_d = ST_SPAWN_RD;
        end else begin
          dec     = 1'b1;
          rd_addr = addr - 1'b1;
          state_d = ST_CHECK_SELF;
        end
      end
      ST_SPAWN_RD: begin
        rd_addr = spawn_addr;
        state_d = ST_SPAWN_WR;
      end
      ST_SPAWN_WR: begin
        if (spawn_en_i && rd_empty) begin
          wr_en   = 1'b1;
          wr_addr = spawn_addr;
          wr_data = SAND_W;
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign ram.rd_addr_o = rd_addr;
  assign ram.wr_addr_o = wr_addr;
  assign ram.wr_data_o = wr_data;
  assign ram.wr_en_o   = wr_en;
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_DONE);

`ifdef CELLS_STATS_EN
  logic [ADDR_WIDTH-1:0] moved_cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      moved_cnt_q   <= '0;
      moved_count_o <= '0;
    end else begin
      if (load)       moved_cnt_q <= '0;
      else if (moved) moved_cnt_q <= moved_cnt_q + 1'b1;
      if (state_q == ST_DONE) moved_count_o <= moved_cnt_q;
    end
  end
`else
  logic unused_moved;
  assign unused_moved = moved;
`endif

endmodule
